// File: rtl/ct_had_dbg_pkg.sv
// Sizing helpers and shared types for the HAD debug-info snapshot buffer.
package ct_had_dbg_pkg;

    localparam int unsigned MaxSnapDepth = 8;
    localparam int unsigned EntryIdxW    = 3;  // enough for MaxSnapDepth entries
    localparam int unsigned WordIdxW     = 8;  // up to 256 words per snapshot

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned snap_words(input int unsigned info_w,
                                               input int unsigned word_w,
                                               input int unsigned ts_words);
        return ceil_div(info_w, word_w) + ts_words;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Address of one word inside the snapshot store.
    typedef struct packed {
        logic [EntryIdxW-1:0] entry;
        logic [WordIdxW-1:0]  word;
    } snap_sel_t;

endpackage

// File: rtl/ct_had_dbg_info_snapshot_if.sv
// HAD register-side drain port of the debug-info snapshot buffer.
interface ct_had_dbg_info_snapshot_if #(
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned SNAP_DEPTH = 2
);
    localparam int unsigned CntW = $clog2(SNAP_DEPTH + 1);

    logic                  dbgfifo_read_ren;
    logic                  dbgfifo_clr;
    logic [WORD_WIDTH-1:0] dbgfifo_data;
    logic                  dbgfifo_empty;
    logic                  dbgfifo_ovf;
    logic [CntW-1:0]       dbgfifo_snap_cnt;

    modport master (
        output dbgfifo_read_ren, dbgfifo_clr,
        input  dbgfifo_data, dbgfifo_empty, dbgfifo_ovf, dbgfifo_snap_cnt
    );

    modport slave (
        input  dbgfifo_read_ren, dbgfifo_clr,
        output dbgfifo_data, dbgfifo_empty, dbgfifo_ovf, dbgfifo_snap_cnt
    );
endinterface

// File: rtl/ct_had_dbg_snap_store.sv
// Unreset SNAP_DEPTH x SWORDS register array: one full-entry write port, one word read mux.
module ct_had_dbg_snap_store
    import ct_had_dbg_pkg::*;
#(
    parameter int unsigned SNAP_DEPTH = 2,
    parameter int unsigned SWORDS     = 6,
    parameter int unsigned WORD_WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [EntryIdxW-1:0]         waddr_i,
    input  logic [SWORDS*WORD_WIDTH-1:0] wdata_i,
    input  snap_sel_t                    rsel_i,
    output logic [WORD_WIDTH-1:0]        rdata_o
);
    logic [SWORDS-1:0][WORD_WIDTH-1:0] mem_q [SNAP_DEPTH];

    always_ff @(posedge clk_i) begin
        for (int unsigned e = 0; e < SNAP_DEPTH; e++) begin
            if (we_i && (waddr_i == EntryIdxW'(e))) begin
                mem_q[e] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned e = 0; e < SNAP_DEPTH; e++) begin
            for (int unsigned w = 0; w < SWORDS; w++) begin
                if ((rsel_i.entry == EntryIdxW'(e)) && (rsel_i.word == WordIdxW'(w))) begin
                    rdata_o = mem_q[e][w];
                end
            end
        end
    end
endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate; enable is captured while clk_in is low.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);
    logic en_lat;

    always_latch begin
        if (!clk_in) begin
            en_lat <= (global_en & (module_en | local_en | external_en)) | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & en_lat;
endmodule

// File: rtl/ct_had_dbg_info_snapshot.sv
// Circular multi-snapshot capture of the wide debug vector, drained one word per read.
// Define CT_HAD_DBG_INFO_TS_EN to prepend a free-running timestamp word to each snapshot.
module ct_had_dbg_info_snapshot
    import ct_had_dbg_pkg::*;
#(
    parameter int unsigned CORE_NUM   = 4,
    parameter int unsigned INFO_WIDTH = 337,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned SNAP_DEPTH = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  pad_yy_icg_scan_en,
    input  logic [CORE_NUM-1:0]   dbg_ack_pc,
    input  logic [INFO_WIDTH-1:0] dbg_info,
    ct_had_dbg_info_snapshot_if.slave had_if
);
`ifdef CT_HAD_DBG_INFO_TS_EN
    localparam int unsigned TsWords = 1;
`else
    localparam int unsigned TsWords = 0;
`endif
    localparam int unsigned WORDS  = ceil_div(INFO_WIDTH, WORD_WIDTH);
    localparam int unsigned SWORDS = snap_words(INFO_WIDTH, WORD_WIDTH, TsWords);
    localparam int unsigned PtrW   = idx_width(SNAP_DEPTH);
    localparam int unsigned WcntW  = idx_width(SWORDS);
    localparam int unsigned CntW   = $clog2(SNAP_DEPTH + 1);

    logic                         gclk, icg_en, ts_en;
    logic                         ack_any, record, rd_vld, last_word, free, cap, drop;
    logic                         ack_f_q;
    logic [PtrW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WcntW-1:0]             wcnt_q, wcnt_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic [WORD_WIDTH-1:0]        data_q, data_d, rd_word;
    logic [WORDS*WORD_WIDTH-1:0]  info_pad;
    logic [SWORDS*WORD_WIDTH-1:0] wdata;
    snap_sel_t                    rsel;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(SNAP_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign info_pad = (WORDS*WORD_WIDTH)'(dbg_info);

`ifdef CT_HAD_DBG_INFO_TS_EN
    logic [WORD_WIDTH-1:0] ts_q;

    always_ff @(posedge gclk or negedge cpurst_b) begin
        if (!cpurst_b) ts_q <= '0;
        else           ts_q <= ts_q + WORD_WIDTH'(1);
    end

    assign ts_en = 1'b1;
    assign wdata = {info_pad, ts_q};
`else
    assign ts_en = 1'b0;
    assign wdata = info_pad;
`endif

    assign icg_en = had_if.dbgfifo_read_ren | had_if.dbgfifo_clr | ack_any | ack_f_q | ts_en;

    gated_clk_cell u_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (1'b0),
        .local_en           (icg_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (gclk)
    );

    assign ack_any   = |dbg_ack_pc;
    assign record    = ack_any & ~ack_f_q;
    assign rd_vld    = had_if.dbgfifo_read_ren & (cnt_q != '0);
    assign last_word = (wcnt_q == WcntW'(SWORDS - 1));
    assign free      = rd_vld & last_word;
    // A same-edge free makes room even when the store is full.
    assign cap       = record & ~had_if.dbgfifo_clr & ((cnt_q < CntW'(SNAP_DEPTH)) | free);
    assign drop      = record & ~cap;

    assign rsel.entry = EntryIdxW'(rptr_q);
    assign rsel.word  = WordIdxW'(wcnt_q);

    ct_had_dbg_snap_store #(
        .SNAP_DEPTH (SNAP_DEPTH),
        .SWORDS     (SWORDS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_store (
        .clk_i   (gclk),
        .we_i    (cap),
        .waddr_i (EntryIdxW'(wptr_q)),
        .wdata_i (wdata),
        .rsel_i  (rsel),
        .rdata_o (rd_word)
    );

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        wcnt_d = wcnt_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        data_d = data_q;
        if (had_if.dbgfifo_clr) begin
            wptr_d = '0;
            rptr_d = '0;
            wcnt_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            data_d = '0;
        end else begin
            if (cap) wptr_d = ptr_inc(wptr_q);
            if (rd_vld) begin
                data_d = rd_word;
                wcnt_d = last_word ? '0 : wcnt_q + WcntW'(1);
            end else if (had_if.dbgfifo_read_ren) begin
                data_d = '0;
            end
            if (free) rptr_d = ptr_inc(rptr_q);
            if (cap && !free)      cnt_d = cnt_q + CntW'(1);
            else if (free && !cap) cnt_d = cnt_q - CntW'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge gclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ack_f_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            ack_f_q <= ack_any;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
        end
    end

    assign had_if.dbgfifo_data     = data_q;
    assign had_if.dbgfifo_empty    = (cnt_q == '0);
    assign had_if.dbgfifo_ovf      = ovf_q;
    assign had_if.dbgfifo_snap_cnt = cnt_q;
endmodule

// File: tb/tb_ct_had_dbg_info_snapshot.sv
// Bench for ct_had_dbg_info_snapshot: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ct_had_dbg_info_snapshot;
    localparam int unsigned CORE_NUM = 4;
    localparam int unsigned INFO_W   = 337;
    localparam int unsigned WW       = 64;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned WORDS    = 6;
`ifdef CT_HAD_DBG_INFO_TS_EN
    localparam int unsigned TS = 1;
`else
    localparam int unsigned TS = 0;
`endif
    localparam int unsigned SW  = WORDS + TS;
    localparam int unsigned SWB = SW * WW;

    logic                clk     = 1'b0;
    logic                rst_n   = 1'b0;
    logic                scan_en = 1'b0;
    logic [CORE_NUM-1:0] ack     = '0;
    logic [INFO_W-1:0]   info    = '0;

    ct_had_dbg_info_snapshot_if #(.WORD_WIDTH(WW), .SNAP_DEPTH(DEPTH)) had_if();

    ct_had_dbg_info_snapshot #(
        .CORE_NUM   (CORE_NUM),
        .INFO_WIDTH (INFO_W),
        .WORD_WIDTH (WW),
        .SNAP_DEPTH (DEPTH)
    ) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_n),
        .pad_yy_icg_scan_en (scan_en),
        .dbg_ack_pc         (ack),
        .dbg_info           (info),
        .had_if             (had_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole snapshots, front one being drained word by word.
    logic [SWB-1:0] m_q[$];
    int             m_widx = 0;
    logic           m_ovf  = 1'b0;
    logic           m_ackf = 1'b0;
    logic [63:0]    m_data = '0;
    logic [63:0]    m_ts   = '0;

    always @(posedge clk) begin : model
        logic           rec;
        logic [SWB-1:0] snap;
        if (!rst_n) begin
            m_q.delete();
            m_widx = 0;
            m_ovf  = 1'b0;
            m_ackf = 1'b0;
            m_data = '0;
            m_ts   = '0;
        end else begin
            rec    = (|ack) && !m_ackf;
            m_ackf = |ack;
            if (had_if.dbgfifo_clr) begin
                m_q.delete();
                m_widx = 0;
                m_ovf  = 1'b0;
                m_data = '0;
            end else begin
                if (had_if.dbgfifo_read_ren) begin
                    if (m_q.size() == 0) begin
                        m_data = '0;
                    end else begin
                        m_data = m_q[0][m_widx*WW +: WW];
                        m_widx++;
                        if (m_widx == SW) begin
                            m_widx = 0;
                            void'(m_q.pop_front());
                        end
                    end
                end
                if (rec) begin
                    if (m_q.size() < DEPTH) begin
                        snap = (SWB'(info) << (TS * WW)) | ((TS != 0) ? SWB'(m_ts) : '0);
                        m_q.push_back(snap);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            m_ts = m_ts + 64'd1;
        end
        #1;
        chk("cyc_data", had_if.dbgfifo_data, m_data);
        chk("cyc_empty", 64'(had_if.dbgfifo_empty), 64'(m_q.size() == 0));
        chk("cyc_ovf", 64'(had_if.dbgfifo_ovf), 64'(m_ovf));
        chk("cyc_cnt", 64'(had_if.dbgfifo_snap_cnt), 64'(m_q.size()));
    end

    task automatic pulse(input int core, input logic [INFO_W-1:0] v);
        @(negedge clk);
        ack[core] = 1'b1;
        info      = v;
        @(negedge clk);
        ack = '0;
        @(negedge clk);
    endtask

    task automatic rd(output logic [63:0] d);
        @(negedge clk);
        had_if.dbgfifo_read_ren = 1'b1;
        @(negedge clk);
        had_if.dbgfifo_read_ren = 1'b0;
        d = had_if.dbgfifo_data;
    endtask

    task automatic clear();
        @(negedge clk);
        had_if.dbgfifo_clr = 1'b1;
        @(negedge clk);
        had_if.dbgfifo_clr = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [63:0] cnt, input logic [63:0] ovf);
        chk({tag, "_cnt"}, 64'(had_if.dbgfifo_snap_cnt), cnt);
        chk({tag, "_empty"}, 64'(had_if.dbgfifo_empty), 64'(cnt == 0));
        chk({tag, "_ovf"}, 64'(had_if.dbgfifo_ovf), ovf);
    endtask

    logic [INFO_W-1:0] pat_a, pat_b, pat_c, pat_d, pat_e;
    logic [63:0]       exp_a[6];
    logic [63:0]       d;
    logic [351:0]      rnd;

    initial begin
        had_if.dbgfifo_read_ren = 1'b0;
        had_if.dbgfifo_clr      = 1'b0;
        exp_a = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_0000_0001,
                  64'h1234_0000_5678_0000, 64'hA5A5_5A5A_C3C3_3C3C, 64'h0000_0000_0001_ABCD};
        pat_a = {17'h1ABCD, 64'hA5A5_5A5A_C3C3_3C3C, 64'h1234_0000_5678_0000,
                 64'hDEAD_BEEF_0000_0001, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        pat_b = INFO_W'(64'hBBBB_BBBB_BBBB_BBBB);
        pat_c = INFO_W'(64'hCCCC_CCCC_CCCC_CCCC);
        pat_d = INFO_W'(64'hDDDD_0000_DDDD_0001);
        pat_e = ~pat_a;

        repeat (2) @(negedge clk);
        chk("rst_data", had_if.dbgfifo_data, 64'h0);
        chk_status("rst", 0, 0);
        rst_n = 1'b1;

`ifndef CT_HAD_DBG_INFO_TS_EN
        // Basic capture and drain.
        pulse(2, pat_a);
        chk_status("cap", 1, 0);
        for (int k = 0; k < 6; k++) begin
            rd(d);
            chk($sformatf("basic_w%0d", k), d, exp_a[k]);
        end
        chk_status("basic_done", 0, 0);

        // Third capture into a full store is dropped.
        pulse(0, pat_a);
        pulse(1, pat_b);
        pulse(3, pat_c);
        chk_status("ovf", 2, 1);
        for (int k = 0; k < 12; k++) begin
            rd(d);
            if (k == 0) chk("ovf_a0", d, exp_a[0]);
            if (k == 5) chk("ovf_a5", d, exp_a[5]);
            if (k == 6) chk("ovf_b0", d, 64'hBBBB_BBBB_BBBB_BBBB);
        end
        chk_status("ovf_done", 0, 1);
        clear();
        chk_status("ovf_clr", 0, 0);

        // Capture lands on the same edge that frees the oldest entry.
        pulse(0, pat_a);
        pulse(1, pat_b);
        for (int k = 0; k < 5; k++) rd(d);
        @(negedge clk);
        had_if.dbgfifo_read_ren = 1'b1;
        ack[1] = 1'b1;
        info   = pat_d;
        @(negedge clk);
        had_if.dbgfifo_read_ren = 1'b0;
        ack = '0;
        chk("sim_a5", had_if.dbgfifo_data, exp_a[5]);
        chk_status("sim", 2, 0);
        for (int k = 0; k < 12; k++) begin
            rd(d);
            if (k == 0) chk("sim_b0", d, 64'hBBBB_BBBB_BBBB_BBBB);
            if (k == 6) chk("sim_d0", d, 64'hDDDD_0000_DDDD_0001);
        end
        chk_status("sim_done", 0, 0);

        // Level held high gives one capture; empty read returns zero.
        @(negedge clk);
        ack  = 4'hF;
        info = pat_a;
        repeat (20) @(negedge clk);
        ack = '0;
        @(negedge clk);
        chk_status("hold", 1, 0);
        for (int k = 0; k < 6; k++) rd(d);
        chk("hold_a5", d, exp_a[5]);
        rd(d);
        chk("empty_rd", d, 64'h0);

        // Clear mid-snapshot, then a fresh capture starts at word 0.
        pulse(2, pat_a);
        for (int k = 0; k < 3; k++) rd(d);
        clear();
        chk("clr_data", had_if.dbgfifo_data, 64'h0);
        chk_status("clr", 0, 0);
        pulse(0, pat_e);
        rd(d);
        chk("clr_e0", d, 64'hFEDC_BA98_7654_3210);

        // Asynchronous reset while mid-read with ovf set.
        pulse(1, pat_a);
        pulse(2, pat_b);
        rd(d);
        chk("pre_rst_e1", d, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_data", had_if.dbgfifo_data, 64'h0);
        chk_status("arst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
`else
        // Timestamp word: capture at counter value 0x40.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (64) @(posedge clk);
        @(negedge clk);
        ack[2] = 1'b1;
        info   = pat_a;
        @(negedge clk);
        ack = '0;
        chk_status("ts_cap", 1, 0);
        for (int k = 0; k < 7; k++) begin
            rd(d);
            if (k == 0) chk("ts_w0", d, 64'h40);
            if (k == 1) chk("ts_a0", d, exp_a[0]);
            if (k == 6) chk("ts_a5", d, exp_a[5]);
        end
        chk_status("ts_done", 0, 0);
`endif

        // Randomized traffic; the model compare runs every cycle.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst_n = (i != 1200);
            ack   = ($urandom_range(0, 3) == 0) ? CORE_NUM'($urandom) : '0;
            had_if.dbgfifo_read_ren = ($urandom_range(0, 2) == 0);
            had_if.dbgfifo_clr      = ($urandom_range(0, 99) == 0);
            for (int j = 0; j < 11; j++) rnd[j*32 +: 32] = $urandom;
            info = rnd[INFO_W-1:0];
        end
        @(negedge clk);
        rst_n = 1'b1;
        ack   = '0;
        had_if.dbgfifo_read_ren = 1'b0;
        had_if.dbgfifo_clr      = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
